// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Interrupt source for the fetch stage. Arbitrates level-sensitive requests
// (lowest enabled index wins), runs a two-cycle redirect handshake toward
// fetch, captures the return PC and cause, and blocks further interrupts
// until the handler returns with mret.
//
// Ports
//   clk_in                       clock, all state on rising edge
//   rst_n_in                     asynchronous active-low reset
//   irq_in[NUM_IRQ]              level requests, bit i = source i
//   irq_enable_in[NUM_IRQ]       per-source mask, 1 = enabled
//   global_enable_in             master enable, sampled only in IDLE
//   pc_in[64]                    byte PC currently presented by fetch
//   mret_signal_in               one-cycle handler-return pulse
//   interrupt_pc_out[64]         vector byte address to fetch
//   interrupt_signal_out         redirect request pulse (REQ cycle)
//   interrupt_pending_signal_out suppresses branch redirects (REQ + ACK)
//   irq_ack_out[NUM_IRQ]         one-hot claim pulse for the taken source (ACK)
//   cause_out[5]                 index of the taken source
//   epc_out[64]                  captured return PC
//   in_service_out               handler active, no new interrupts accepted
//   fsm_state_out[2]             debug view of the controller state
//
// Handshake: there is no backpressure. interrupt_signal_out is a one-cycle
// "valid" toward fetch; fetch is always ready and loads interrupt_pc_out at
// the closing edge of the following ACK cycle. interrupt_pending_signal_out
// brackets both cycles so fetch ignores its own redirects meanwhile.

module interrupt_controller #(
    parameter int          NUM_IRQ       = 8,
    parameter logic [63:0] VECTOR_BASE   = 64'h0000_0000_0000_0100,
    parameter int          VECTOR_STRIDE = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_enable_in,
    input  logic               global_enable_in,
    input  logic [63:0]        pc_in,
    input  logic               mret_signal_in,
    output logic [63:0]        interrupt_pc_out,
    output logic               interrupt_signal_out,
    output logic               interrupt_pending_signal_out,
    output logic [NUM_IRQ-1:0] irq_ack_out,
    output logic [4:0]         cause_out,
    output logic [63:0]        epc_out,
    output logic               in_service_out,
    output logic [1:0]         fsm_state_out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    logic [1:0]         state;
    logic [NUM_IRQ-1:0] active;
    logic [4:0]         take_id;
    logic [63:0]        vector_addr;

    assign active = irq_in & irq_enable_in;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        take_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                take_id = 5'(i);
            end
        end
    end

    // Unsigned 64-bit arithmetic; overflow wraps modulo 2^64 by design.
    assign vector_addr = VECTOR_BASE + (64'(take_id) * 64'(VECTOR_STRIDE));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= ST_IDLE;
            cause_out        <= '0;
            interrupt_pc_out <= '0;
            epc_out          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (global_enable_in && (active != '0)) begin
                        state            <= ST_REQ;
                        cause_out        <= take_id;
                        interrupt_pc_out <= vector_addr;
                    end
                end
                ST_REQ: begin
                    // The PC fetch shows while the redirect is requested is
                    // the instruction the handler must return to.
                    epc_out <= pc_in;
                    state   <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (mret_signal_in) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the state register, so no input reaches an
    // output combinationally and they clear the instant reset asserts.
    assign interrupt_signal_out         = (state == ST_REQ);
    assign interrupt_pending_signal_out = (state == ST_REQ) || (state == ST_ACK);
    assign in_service_out               = (state == ST_SERVICE);
    assign irq_ack_out                  = (state == ST_ACK) ? (NUM_IRQ'(1) << cause_out)
                                                            : '0;
    assign fsm_state_out                = state;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    localparam int          N      = 8;
    localparam logic [63:0] BASE   = 64'h0000_0000_0000_0100;
    localparam logic [63:0] BASE_W = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam int          STRIDE = 4;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [N-1:0] irq_in = '0;
    logic [N-1:0] irq_enable_in = '0;
    logic         global_enable_in = 1'b0;
    logic [63:0]  pc_in = '0;
    logic         mret_signal_in = 1'b0;

    logic [63:0]  interrupt_pc_out, epc_out;
    logic         interrupt_signal_out, interrupt_pending_signal_out, in_service_out;
    logic [N-1:0] irq_ack_out;
    logic [4:0]   cause_out;
    logic [1:0]   fsm_state_out;

    logic [63:0]  w_pc, w_epc;
    logic         w_sig, w_pend, w_svc;
    logic [N-1:0] w_ack;
    logic [4:0]   w_cause;
    logic [1:0]   w_state;

    interrupt_controller #(.NUM_IRQ(N), .VECTOR_BASE(BASE), .VECTOR_STRIDE(STRIDE)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .irq_in(irq_in), .irq_enable_in(irq_enable_in),
        .global_enable_in(global_enable_in), .pc_in(pc_in), .mret_signal_in(mret_signal_in),
        .interrupt_pc_out(interrupt_pc_out), .interrupt_signal_out(interrupt_signal_out),
        .interrupt_pending_signal_out(interrupt_pending_signal_out), .irq_ack_out(irq_ack_out),
        .cause_out(cause_out), .epc_out(epc_out), .in_service_out(in_service_out),
        .fsm_state_out(fsm_state_out)
    );

    // Second instance with a vector base near the top of the address space.
    interrupt_controller #(.NUM_IRQ(N), .VECTOR_BASE(BASE_W), .VECTOR_STRIDE(STRIDE)) dut_w (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .irq_in(irq_in), .irq_enable_in(irq_enable_in),
        .global_enable_in(global_enable_in), .pc_in(pc_in), .mret_signal_in(mret_signal_in),
        .interrupt_pc_out(w_pc), .interrupt_signal_out(w_sig),
        .interrupt_pending_signal_out(w_pend), .irq_ack_out(w_ack),
        .cause_out(w_cause), .epc_out(w_epc), .in_service_out(w_svc),
        .fsm_state_out(w_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [132:0] exp_q[$];   // {cause, pc, wrapped pc} per taken interrupt
    logic [71:0]  ack_q[$];   // {one-hot ack, epc} per taken interrupt

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: a request taken at edge T gives the pulse in the cycle
    // after T, the ack in the cycle after T+1, service after T+2, and mret is
    // honoured from edge T+3 onward.
    int          edge_i = 0;
    int          taken = -10;
    bit          busy = 0;
    logic [4:0]  h_cause = '0;
    logic [63:0] h_pc = '0;
    logic [63:0] h_epc = '0;

    task automatic model_step();
        logic [N-1:0] act;
        int id;
        edge_i++;
        if (!rst_n_in) begin
            busy = 0; h_cause = '0; h_pc = '0; h_epc = '0;
            exp_q.delete(); ack_q.delete();
            return;
        end
        act = irq_in & irq_enable_in;
        if (busy) begin
            if (edge_i == taken + 1) begin
                h_epc = pc_in;
                ack_q.push_back({N'(1) << h_cause, pc_in});
            end
            if (edge_i >= taken + 3 && mret_signal_in) busy = 0;
        end else if (global_enable_in && act != '0) begin
            id = -1;
            for (int i = 0; i < N; i++) if (act[i] && id < 0) id = i;
            h_cause = 5'(id);
            h_pc = BASE + 64'(id) * 64'(STRIDE);
            exp_q.push_back({h_cause, h_pc, BASE_W + 64'(id) * 64'(STRIDE)});
            taken = edge_i;
            busy = 1;
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    // ---------------- monitor ----------------
    initial forever begin
        logic [132:0] e;
        logic [71:0]  a;
        bit e_sig, e_pend, e_ackph, e_svc;
        @(negedge clk_in);
        if (rst_n_in) begin
            e_sig   = busy && edge_i == taken;
            e_pend  = busy && (edge_i == taken || edge_i == taken + 1);
            e_ackph = busy && edge_i == taken + 1;
            e_svc   = busy && edge_i >= taken + 2;
            chk("sig", 64'(interrupt_signal_out), 64'(e_sig));
            chk("pend", 64'(interrupt_pending_signal_out), 64'(e_pend));
            chk("svc", 64'(in_service_out), 64'(e_svc));
            chk("ack_phase", 64'(irq_ack_out != '0), 64'(e_ackph));
            chk("w_sig", 64'(w_sig), 64'(e_sig));
            if (interrupt_signal_out) begin
                if (exp_q.size() == 0) chk("pulse_unexpected", 64'(1), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("cause", 64'(cause_out), 64'(e[132:128]));
                    chk("vec_pc", interrupt_pc_out, e[127:64]);
                    chk("vec_pc_wrap", w_pc, e[63:0]);
                end
            end
            if (irq_ack_out != '0) begin
                if (ack_q.size() == 0) chk("ack_unexpected", 64'(1), 64'(0));
                else begin
                    a = ack_q.pop_front();
                    chk("ack_onehot", 64'(irq_ack_out), 64'(a[71:64]));
                    chk("epc", epc_out, a[63:0]);
                end
            end
            if (e_svc) begin
                chk("hold_cause", 64'(cause_out), 64'(h_cause));
                chk("hold_pc", interrupt_pc_out, h_pc);
                chk("hold_epc", epc_out, h_epc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic mret_pulse();
        mret_signal_in = 1'b1;
        @(negedge clk_in);
        mret_signal_in = 1'b0;
    endtask

    // Leaves the caller at the negedge of the REQ cycle.
    task automatic wait_pulse(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (!interrupt_signal_out && k < 20);
        chk({name, "_timeout"}, 64'(interrupt_signal_out), 64'(1));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pc"}, interrupt_pc_out, 64'(0));
        chk({name, "_epc"}, epc_out, 64'(0));
        chk({name, "_cause"}, 64'(cause_out), 64'(0));
        chk({name, "_ack"}, 64'(irq_ack_out), 64'(0));
        chk({name, "_strobes"}, 64'({interrupt_signal_out, interrupt_pending_signal_out, in_service_out}), 64'(0));
        chk({name, "_wpc"}, w_pc, 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        tick(3);
        chk_all_zero("reset");
        rst_n_in = 1'b1;

        // Global gate: enabled active request but master enable low.
        irq_in = 8'hFF; irq_enable_in = 8'hFF; global_enable_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk_all_zero("global_off");
        end

        // Single source 2.
        irq_in = 8'h00; global_enable_in = 1'b1; pc_in = 64'h40;
        tick(2);
        irq_in = 8'h04;
        wait_pulse("src2");
        chk("src2_cause", 64'(cause_out), 64'd2);
        chk("src2_pc", interrupt_pc_out, 64'h108);
        chk("src2_wrap_pc", w_pc, 64'h4);
        chk("src2_pend_req", 64'(interrupt_pending_signal_out), 64'd1);
        @(negedge clk_in);
        chk("src2_ack", 64'(irq_ack_out), 64'h04);
        chk("src2_pend_ack", 64'(interrupt_pending_signal_out), 64'd1);
        chk("src2_sig_ack", 64'(interrupt_signal_out), 64'd0);
        chk("src2_epc", epc_out, 64'h40);
        irq_in = 8'h00;
        @(negedge clk_in);
        chk("src2_svc", 64'(in_service_out), 64'd1);
        chk("src2_pend_svc", 64'(interrupt_pending_signal_out), 64'd0);

        // No nesting: request held through service, then back-to-back.
        irq_in = 8'h01;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (interrupt_signal_out) cnt++;
        end
        chk("no_nesting", 64'(cnt), 64'd0);
        mret_pulse();                          // now in cycle M+1
        chk("b2b_idle_sig", 64'(interrupt_signal_out), 64'd0);
        chk("b2b_idle_svc", 64'(in_service_out), 64'd0);
        @(negedge clk_in);                     // cycle M+2
        chk("b2b_sig", 64'(interrupt_signal_out), 64'd1);
        chk("b2b_cause", 64'(cause_out), 64'd0);
        chk("b2b_pc", interrupt_pc_out, 64'h100);
        irq_in = 8'h00;
        tick(3);

        // Priority and mask.
        mret_pulse();
        irq_in = 8'h24; irq_enable_in = 8'hFB;
        wait_pulse("prio");
        chk("prio_cause", 64'(cause_out), 64'd5);
        chk("prio_pc", interrupt_pc_out, 64'h114);
        irq_in = 8'h00;
        tick(3);
        mret_pulse();
        irq_in = 8'h24; irq_enable_in = 8'hDB;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (interrupt_signal_out || interrupt_pending_signal_out) cnt++;
        end
        chk("masked", 64'(cnt), 64'd0);

        // Wrap, then reset asserted during ACK.
        irq_in = 8'h02; irq_enable_in = 8'hFF;
        wait_pulse("wrap");
        chk("wrap_pc", w_pc, 64'h0);
        chk("wrap_norm_pc", interrupt_pc_out, 64'h104);
        @(posedge clk_in);
        #2;
        chk("mid_ack_check", 64'(interrupt_pending_signal_out), 64'd1);
        rst_n_in = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        irq_in = 8'h00;
        tick(2);
        rst_n_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (fsm_state_out != 2'd0 || interrupt_signal_out) cnt++;
        end
        chk("stay_idle", 64'(cnt), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            irq_in = N'($urandom_range(0, 255)) & N'($urandom_range(0, 255));
            irq_enable_in = N'($urandom_range(0, 255));
            global_enable_in = ($urandom_range(0, 3) != 0);
            pc_in = {$urandom, $urandom};
            mret_signal_in = ($urandom_range(0, 3) == 0);
            @(negedge clk_in);
        end
        irq_in = '0; mret_signal_in = 1'b1;
        tick(6);
        mret_signal_in = 1'b0;
        tick(2);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
